// File: rtl/mesi_isc_tb_snoop_resp.sv
// CPU-side coherence responder: tracks per-line MESI state for one testbench CPU,
// acknowledges cbus snoops/enables and writes back Modified lines on the mbus first.
module mesi_isc_tb_snoop_resp #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  input  logic                      cbus_shared_i,
  output logic                      cbus_ack_o,
  output logic [1:0]                mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
  input  logic                      mbus_ack_i,
  output logic [4*NUM_LINES-1:0]    cache_state_o,
  output logic                      busy_o,
  output logic                      cmd_err_o,
  output logic [CNT_WIDTH-1:0]      snoop_cnt_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WB    = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CMD_EN_RD    = 3'd4;

  localparam logic [1:0] MB_NOP = 2'd0;
  localparam logic [1:0] MB_WB  = 2'd1;

  localparam logic [3:0] MESI_M = 4'b1001;
  localparam logic [3:0] MESI_E = 4'b0101;
  localparam logic [3:0] MESI_S = 4'b0011;
  localparam logic [3:0] MESI_I = 4'b0000;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_op_wr;
  logic [3:0]            r_line [NUM_LINES];
  logic                  r_ack;
  logic [1:0]            r_mbus_cmd;
  logic [ADDR_WIDTH-1:0] r_mbus_addr;
  logic                  r_busy;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [1:0]            w_nxt_state;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic                  w_nxt_op_wr;
  logic                  w_nxt_ack;
  logic [1:0]            w_nxt_mbus_cmd;
  logic [ADDR_WIDTH-1:0] w_nxt_mbus_addr;
  logic                  w_nxt_err;
  logic                  w_cnt_inc;
  logic                  w_line_we;
  logic [ADDR_WIDTH-1:0] w_line_idx;
  logic [3:0]            w_line_val;
  logic [3:0]            w_cur;

  assign w_cur = r_line[cbus_addr_i];

  // Next-state, line-update and registered-output decode
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_addr      = r_addr;
    w_nxt_op_wr     = r_op_wr;
    w_nxt_ack       = 1'b0;
    w_nxt_mbus_cmd  = r_mbus_cmd;
    w_nxt_mbus_addr = r_mbus_addr;
    w_nxt_err       = 1'b0;
    w_cnt_inc       = 1'b0;
    w_line_we       = 1'b0;
    w_line_idx      = cbus_addr_i;
    w_line_val      = MESI_I;
    case (r_state)
      ST_IDLE: begin
        case (cbus_cmd_i)
          CMD_NOP: ;
          CMD_WR_SNOOP, CMD_RD_SNOOP: begin
            w_nxt_addr  = cbus_addr_i;
            w_nxt_op_wr = (cbus_cmd_i == CMD_WR_SNOOP);
            if (w_cur == MESI_M) begin
              w_nxt_state     = ST_WB;
              w_nxt_mbus_cmd  = MB_WB;
              w_nxt_mbus_addr = cbus_addr_i;
            end else begin
              w_line_we   = 1'b1;
              w_line_val  = (cbus_cmd_i == CMD_WR_SNOOP || w_cur == MESI_I) ? MESI_I : MESI_S;
              w_nxt_state = ST_ACK;
              w_nxt_ack   = 1'b1;
              w_cnt_inc   = 1'b1;
            end
          end
          CMD_EN_WR: begin
            w_nxt_addr  = cbus_addr_i;
            w_line_we   = 1'b1;
            w_line_val  = MESI_M;
            w_nxt_state = ST_ACK;
            w_nxt_ack   = 1'b1;
          end
          CMD_EN_RD: begin
            w_nxt_addr  = cbus_addr_i;
            w_line_we   = 1'b1;
            w_line_val  = cbus_shared_i ? MESI_S : MESI_E;
            w_nxt_state = ST_ACK;
            w_nxt_ack   = 1'b1;
          end
          default: w_nxt_err = 1'b1;
        endcase
      end
      ST_WB: begin
        if (mbus_ack_i) begin
          w_nxt_mbus_cmd = MB_NOP;
          w_line_we      = 1'b1;
          w_line_idx     = r_addr;
          w_line_val     = r_op_wr ? MESI_I : MESI_S;
          w_nxt_state    = ST_ACK;
          w_nxt_ack      = 1'b1;
          w_cnt_inc      = 1'b1;
        end
      end
      ST_ACK:   w_nxt_state = ST_DRAIN;
      default: begin
        if (cbus_cmd_i == CMD_NOP) w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_op_wr     <= 1'b0;
      r_ack       <= 1'b0;
      r_mbus_cmd  <= MB_NOP;
      r_mbus_addr <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      for (int n = 0; n < int'(NUM_LINES); n++) r_line[n] <= MESI_I;
    end else begin
      r_state     <= w_nxt_state;
      r_addr      <= w_nxt_addr;
      r_op_wr     <= w_nxt_op_wr;
      r_ack       <= w_nxt_ack;
      r_mbus_cmd  <= w_nxt_mbus_cmd;
      r_mbus_addr <= w_nxt_mbus_addr;
      r_busy      <= (w_nxt_state != ST_IDLE);
      r_err       <= w_nxt_err;
      // Snoop counter saturates rather than wrapping
      if (w_cnt_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_line_we) r_line[w_line_idx] <= w_line_val;
    end
  end

  genvar g;
  generate
    for (g = 0; g < int'(NUM_LINES); g++) begin : g_state
      assign cache_state_o[4*g +: 4] = r_line[g];
    end
  endgenerate

  assign cbus_ack_o  = r_ack;
  assign mbus_cmd_o  = r_mbus_cmd;
  assign mbus_addr_o = r_mbus_addr;
  assign busy_o      = r_busy;
  assign cmd_err_o   = r_err;
  assign snoop_cnt_o = r_cnt;

endmodule

// File: tb/tb_mesi_isc_tb_snoop_resp.sv
// Bench for mesi_isc_tb_snoop_resp: transaction-level MESI model drives expectations,
// a negedge process compares every output each cycle.
module tb_mesi_isc_tb_snoop_resp;

  localparam int unsigned AW = 2;
  localparam int unsigned NL = 4;
  localparam int unsigned CW = 16;

  localparam logic [3:0] M_ST = 4'b1001;
  localparam logic [3:0] E_ST = 4'b0101;
  localparam logic [3:0] S_ST = 4'b0011;
  localparam logic [3:0] I_ST = 4'b0000;

  logic          clk;
  logic          rst;
  logic [2:0]    cbus_cmd_i;
  logic [AW-1:0] cbus_addr_i;
  logic          cbus_shared_i;
  logic          cbus_ack_o;
  logic [1:0]    mbus_cmd_o;
  logic [AW-1:0] mbus_addr_o;
  logic          mbus_ack_i;
  logic [4*NL-1:0] cache_state_o;
  logic          busy_o;
  logic          cmd_err_o;
  logic [CW-1:0] snoop_cnt_o;

  mesi_isc_tb_snoop_resp #(.ADDR_WIDTH(AW), .NUM_LINES(NL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_shared_i(cbus_shared_i),
    .cbus_ack_o(cbus_ack_o),
    .mbus_cmd_o(mbus_cmd_o), .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
    .cache_state_o(cache_state_o), .busy_o(busy_o), .cmd_err_o(cmd_err_o),
    .snoop_cnt_o(snoop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state and expected outputs for the current cycle
  logic [3:0]    m_line [NL];
  logic          exp_ack, exp_busy, exp_err;
  logic [1:0]    exp_mbus;
  logic [AW-1:0] exp_maddr;
  int            exp_cnt;
  logic          chk_en;
  int            n_cmp = 0;
  int            n_err = 0;
  int            dut_wb_cycles, dut_acks, dut_errs;

  function automatic logic [4*NL-1:0] model_vec();
    logic [4*NL-1:0] v;
    v = '0;
    for (int n = 0; n < int'(NL); n++) v[4*n +: 4] = m_line[n];
    return v;
  endfunction

  function automatic logic [3:0] snoop_next(input logic wr, input logic [3:0] cur);
    if (wr || cur == I_ST) return I_ST;
    return S_ST;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cache_state", 32'(cache_state_o), 32'(model_vec()));
      cmp("cbus_ack", 32'(cbus_ack_o), 32'(exp_ack));
      cmp("mbus_cmd", 32'(mbus_cmd_o), 32'(exp_mbus));
      if (exp_mbus == 2'd1) cmp("mbus_addr", 32'(mbus_addr_o), 32'(exp_maddr));
      cmp("busy", 32'(busy_o), 32'(exp_busy));
      cmp("cmd_err", 32'(cmd_err_o), 32'(exp_err));
      cmp("snoop_cnt", 32'(snoop_cnt_o), 32'(exp_cnt));
      if (mbus_cmd_o == 2'd1) dut_wb_cycles++;
      if (cbus_ack_o) dut_acks++;
      if (cmd_err_o) dut_errs++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_ack = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic set_reset_exp();
    for (int n = 0; n < int'(NL); n++) m_line[n] = I_ST;
    exp_mbus = 2'd0; exp_busy = 1'b0; exp_cnt = 0;
    exp_ack = 1'b0; exp_err = 1'b0; exp_maddr = '0;
  endtask

  // Issue one cbus command in the current (idle) cycle; returns in the first idle cycle after
  task automatic do_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr, input logic sh,
                        input int d, input int hold);
    logic [3:0] nv;
    logic       is_snp, wb;
    cbus_cmd_i = cmd; cbus_addr_i = addr; cbus_shared_i = sh;
    if (cmd == 3'd0) begin step(); return; end
    if (cmd > 3'd4) begin
      step();
      exp_err = 1'b1;
      cbus_cmd_i = 3'd0;
      return;
    end
    is_snp = (cmd == 3'd1) || (cmd == 3'd2);
    wb     = is_snp && (m_line[addr] == M_ST);
    case (cmd)
      3'd1, 3'd2: nv = snoop_next(cmd == 3'd1, m_line[addr]);
      3'd3:       nv = M_ST;
      default:    nv = sh ? S_ST : E_ST;
    endcase
    step();
    exp_busy = 1'b1;
    if (wb) begin
      exp_mbus = 2'd1; exp_maddr = addr;
      for (int k = 0; k < d; k++) step();
      mbus_ack_i = 1'b1;
      step();
      mbus_ack_i = 1'b0;
      exp_mbus = 2'd0;
    end
    m_line[addr] = nv;
    exp_ack = 1'b1;
    if (is_snp && exp_cnt < 65535) exp_cnt++;
    for (int j = 1; j <= hold + 1; j++) begin
      step();
      if (j == hold + 1) cbus_cmd_i = 3'd0;
    end
    step();
    exp_busy = 1'b0;
  endtask

  initial begin
    chk_en = 1'b0;
    rst = 1'b0; cbus_cmd_i = 3'd0; cbus_addr_i = '0; cbus_shared_i = 1'b0; mbus_ack_i = 1'b0;
    step();
    set_reset_exp();
    chk_en = 1'b1;
    step();
    rst = 1'b1;
    cmp("rst_state", 32'(cache_state_o), 32'h0);
    cmp("rst_ack", 32'(cbus_ack_o), 32'h0);
    cmp("rst_mbus", 32'(mbus_cmd_o), 32'h0);
    cmp("rst_cnt", 32'(snoop_cnt_o), 32'h0);

    do_cmd(3'd4, 2'd2, 1'b0, 0, 0);
    cmp("en_rd_excl", 32'(cache_state_o), 32'h0500);
    do_cmd(3'd4, 2'd3, 1'b1, 0, 0);
    cmp("en_rd_shared", 32'(cache_state_o), 32'h3500);
    do_cmd(3'd3, 2'd1, 1'b0, 0, 0);
    cmp("en_wr", 32'(cache_state_o), 32'h3590);

    dut_wb_cycles = 0; dut_acks = 0;
    do_cmd(3'd1, 2'd1, 1'b0, 3, 0);
    cmp("wr_snoop_state", 32'(cache_state_o), 32'h3500);
    cmp("wr_snoop_wb_cycles", 32'(dut_wb_cycles), 32'd4);
    cmp("wr_snoop_cnt", 32'(snoop_cnt_o), 32'd1);

    do_cmd(3'd4, 2'd0, 1'b0, 0, 0);
    dut_wb_cycles = 0; dut_acks = 0;
    do_cmd(3'd2, 2'd0, 1'b0, 0, 4);
    cmp("rd_snoop_state", 32'(cache_state_o), 32'h3503);
    cmp("rd_snoop_one_ack", 32'(dut_acks), 32'd1);
    cmp("rd_snoop_no_wb", 32'(dut_wb_cycles), 32'd0);

    dut_errs = 0; dut_acks = 0;
    do_cmd(3'd6, 2'd1, 1'b0, 0, 0);
    step();
    cmp("illegal_err_pulse", 32'(dut_errs), 32'd1);
    cmp("illegal_no_ack", 32'(dut_acks), 32'd0);
    cmp("illegal_state", 32'(cache_state_o), 32'h3503);

    do_cmd(3'd3, 2'd2, 1'b0, 0, 0);
    do_cmd(3'd2, 2'd2, 1'b0, 1, 1);
    cmp("rd_snoop_m_state", 32'(cache_state_o), 32'h3303);
    cmp("rd_snoop_m_cnt", 32'(snoop_cnt_o), 32'd3);

    // Reset while waiting for writeback acknowledge
    do_cmd(3'd3, 2'd0, 1'b0, 0, 0);
    cbus_cmd_i = 3'd1; cbus_addr_i = 2'd0;
    step();
    exp_busy = 1'b1; exp_mbus = 2'd1; exp_maddr = 2'd0;
    step();
    step();
    dut_acks = 0;
    rst = 1'b0; cbus_cmd_i = 3'd0;
    step();
    set_reset_exp();
    rst = 1'b1;
    cmp("mid_rst_mbus", 32'(mbus_cmd_o), 32'h0);
    cmp("mid_rst_state", 32'(cache_state_o), 32'h0);
    step();
    cmp("mid_rst_no_ack", 32'(dut_acks), 32'd0);
    do_cmd(3'd3, 2'd0, 1'b0, 0, 0);
    cmp("post_rst_en_wr", 32'(cache_state_o), 32'h0009);

    for (int t = 0; t < 400; t++) begin
      do_cmd(3'($urandom_range(0, 7)), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mesi_isc_tb_snoop_resp.md
Name: mesi_isc_tb_snoop_resp

Overview:
CPU-side responder for coherence-bus (cbus) traffic issued by the MESI ISC toward one testbench CPU. It maintains that CPU's per-line MESI state and answers broadcast snoops and grant enables with an acknowledge. When a snooped line is Modified, it performs a memory-bus writeback first. One instance sits beside each mesi_isc_tb CPU model, and its state outputs feed the coherence assertion checker.

Parameters:
ADDR_WIDTH, 2, cbus/mbus line-address width
NUM_LINES, 4, tracked cache lines (= 2**ADDR_WIDTH)
CNT_WIDTH, 16, width of snoop statistics counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low
cbus_cmd_i  input  3  0=NOP, 1=WR_SNOOP, 2=RD_SNOOP, 3=EN_WR, 4=EN_RD, 5-7 illegal
cbus_addr_i  input  ADDR_WIDTH  line address of cbus command
cbus_shared_i  input  1  with EN_RD: another CPU holds the line
cbus_ack_o  output  1  one-cycle acknowledge of current cbus command
mbus_cmd_o  output  2  0=NOP, 1=WB (writeback)
mbus_addr_o  output  ADDR_WIDTH  writeback line address
mbus_ack_i  input  1  memory accepted writeback
cache_state_o  output  4*NUM_LINES  line n state at [4n+3:4n], MESI_ISC_TB_CPU_MESI_* codes
busy_o  output  1  FSM not in IDLE
cmd_err_o  output  1  one-cycle pulse on illegal cbus command
snoop_cnt_o  output  CNT_WIDTH  count of acknowledged WR/RD snoops

Behaviour:
- Reset (rst==0 at posedge): all lines = MESI_I; cbus_ack_o=0, mbus_cmd_o=NOP, mbus_addr_o=0, busy_o=0, cmd_err_o=0, snoop_cnt_o=0, FSM=IDLE. Reset mid-transaction aborts immediately; no ack is issued and the writeback is dropped.
- FSM states: IDLE, WB, ACK, DRAIN.
- IDLE: sample cbus_cmd_i/cbus_addr_i each cycle; latch the address on acceptance.
  - WR_SNOOP: line M -> WB. Line E/S/I -> set I, go ACK.
  - RD_SNOOP: line M -> WB. Line E/S -> set S, go ACK. Line I stays I, go ACK.
  - EN_WR: set M, go ACK.
  - EN_RD: set S if cbus_shared_i=1, else E; go ACK.
  - Illegal code: pulse cmd_err_o for one cycle, no state change, stay IDLE.
  - NOP: stay IDLE.
- WB: mbus_cmd_o=WB and mbus_addr_o=latched address, held stable until mbus_ack_i=1.
  - On the ack cycle: mbus_cmd_o returns to NOP next cycle; line becomes I (WR_SNOOP) or S (RD_SNOOP); go ACK.
  - No timeout.
- ACK: cbus_ack_o=1 for exactly one cycle. State update is visible on cache_state_o in the same cycle as the ack. snoop_cnt_o increments on WR/RD snoop acks and saturates at all-ones. Go DRAIN.
- DRAIN: wait until cbus_cmd_i==NOP, then go IDLE. A held command is never acked twice. Entry into IDLE with a new non-NOP command the same cycle is allowed.
- Latency, non-M paths: command accepted at cycle t, ack at t+1.
- Latency, M paths: ack arrives one cycle after mbus_ack_i.
- Only one command in flight; cbus inputs are ignored outside IDLE/DRAIN.
- Each line changes only when addressed; other lines hold.

Test Plan:
- Reset: rst=0 for 2 cycles -> cache_state_o=all MESI_I, cbus_ack_o=0, mbus_cmd_o=0, snoop_cnt_o=0.
- EN_RD addr 2, cbus_shared_i=0 -> ack next cycle, line2=E. Then EN_RD addr 3, shared=1 -> line3=S.
- EN_WR addr 1, then WR_SNOOP addr 1 with mbus_ack_i delayed 3 cycles:
  - mbus_cmd_o=WB, mbus_addr_o=1 held for 4 cycles.
  - ack one cycle after mbus_ack_i, line1=I, snoop_cnt_o=1.
- Line0=E, RD_SNOOP addr 0 -> no mbus activity, ack at t+1, line0=S. Command held 5 cycles -> exactly one ack.
- cbus_cmd_i=6 -> cmd_err_o one pulse, no ack, states unchanged.
- rst=0 during WB wait -> next cycle mbus_cmd_o=NOP, all lines I, no ack; after release, EN_WR addr 0 -> line0=M.
